pdm_mic_rx: RTL and testbench
=============================

Name: pdm_mic_rx

Overview:
- Parametrised PDM microphone front end: generates the mic clock from the system clock, in standard or ultrasonic mode.
- Samples one or two PDM channels (L/R share one data line) and decimates each with a boxcar ones-counter.
- Delivers signed PCM samples through a one-entry valid/ready output buffer with sticky overrun.
- Sits between the microphone pins and the audio buffer/FIFO.

Parameters:
- DIV_STD, 12, mic_clk half-period in clk cycles, standard mode (48 MHz -> 2 MHz); must be >= 1
- DIV_ULTRA, 6, mic_clk half-period in clk cycles, ultrasonic mode (48 MHz -> 4 MHz); must be >= 1
- DECIM, 64, mic_clk periods per output sample; must be >= 2
- OUT_W, 16, PCM sample width; must be >= clog2(DECIM)+2
- STEREO, 1, 1 = capture L and R; 0 = L only

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  run capture; 0 = idle
- mode_ultra  in  1  0 = DIV_STD, 1 = DIV_ULTRA
- pdm_data  in  1  PDM data from microphone(s), already synchronised
- mic_clk  out  1  clock to microphone(s), registered
- sample_l  out  OUT_W  signed PCM, left
- sample_r  out  OUT_W  signed PCM, right; constant 0 when STEREO=0
- sample_valid  out  1  output buffer holds an unconsumed sample pair
- sample_ready  in  1  consumer accepts the pair when sample_valid && sample_ready
- overrun  out  1  sticky: a pair was overwritten before being consumed
- clr_overrun  in  1  clears overrun

Behaviour:
- Reset values: mic_clk=1, sample_l=0, sample_r=0, sample_valid=0, overrun=0. Internal half-period counter, period counter and accumulators are 0. The mode latch takes mode_ultra's value at reset release.
- Clock generation:
  - Half-period counter hc runs 0..D-1, where D is the latched divider. At hc==D-1 (terminal cycle) mic_clk toggles and hc returns to 0.
  - The mode latch updates only on a terminal cycle. A mode change therefore takes effect from the next half-period, and no half-period is ever truncated.
- Idle: enable=0 holds mic_clk=1, hc=0, period counter=0 and accumulators=0. The output buffer, sample_valid and overrun keep their values.
  - Deasserting enable mid-block discards the partial block.
  - Reasserting enable starts a fresh block, whose first event is a falling toggle after D cycles.
- Sampling (pdm_data is captured on the terminal cycle, i.e. at the end of each half-period):
  - Terminal cycle with mic_clk==1 (falling toggle): left sample; if pdm_data=1, ones_l increments.
  - Terminal cycle with mic_clk==0 (rising toggle): right sample when STEREO=1, otherwise ignored; this toggle ends one mic_clk period.
- Block end: on the rising toggle that completes period DECIM-1, each channel's result is 2*ones - DECIM (range -DECIM..+DECIM), sign-extended to OUT_W.
  - Accumulators and the period counter clear in that same cycle. The next block's first sample is counted from zero, with no lost bits.
- Output buffer:
  - The result is loaded into sample_l/sample_r and sample_valid=1 on the cycle after the block-end toggle, giving 1-cycle latency from the final rising toggle.
  - A handshake (valid && ready) with no load pending clears sample_valid on the next cycle.
  - Load and handshake in the same cycle: the new pair is loaded, sample_valid stays 1, no overrun.
  - Load while valid && !ready: the new pair overwrites the old and overrun sets.
- overrun clears only via clr_overrun. If overrun sets and clr_overrun is asserted in the same cycle, set wins.
- Widths: ones counters are clog2(DECIM+1) bits; arithmetic is signed, with no saturation needed given the OUT_W constraint.

Test Plan:
- Reset: assert rst_n=0 with enable=1 -> mic_clk=1, sample_valid=0, sample_l=sample_r=0, overrun=0. Release rst_n -> first mic_clk fall exactly DIV_STD cycles later.
- Clock rate: enable=1, mode_ultra=0, defaults -> mic_clk toggles every 12 cycles (24-cycle period). mode_ultra=1 -> toggles every 6 cycles. Switch mode_ultra at hc=8 -> current half-period still lasts 12 cycles, then 6-cycle half-periods.
- Decimation values, DECIM=64, STEREO=1:
  - pdm_data=1 on every falling terminal, 0 on every rising terminal -> sample_l=+64, sample_r=-64.
  - Left alternating 1,0 -> sample_l=0.
  - sample_valid rises 1 cycle after the 64th rising toggle.
- Backpressure, DIV_STD=2, DECIM=4: sample_ready=0 across two blocks -> second block's values held, overrun=1. Pulse clr_overrun -> overrun=0. Load coinciding with a handshake -> no overrun, sample_valid stays 1.
- Enable abort, DECIM=4: feed all-ones, drop enable after 2 periods for 10 cycles, re-enable with all-zeros -> first sample after restart is sample_l=-4 (no stale ones counted). A pending sample_valid persists through idle.
- Mono, STEREO=0: pdm_data=1 always -> sample_l=+DECIM, sample_r=0 in every sample.

Source files
------------

// File: rtl/pdm_mic_rx_if.sv
// PCM sample-pair stream between the PDM receiver and the audio buffer.
// The producer holds a pair until the consumer takes it with valid && ready.
interface pdm_mic_rx_if #(
    parameter int OUT_W = 16
);
    logic [OUT_W-1:0] sample_l;
    logic [OUT_W-1:0] sample_r;
    logic             sample_valid;
    logic             sample_ready;

    modport master (output sample_l, output sample_r, output sample_valid, input sample_ready);
    modport slave  (input sample_l, input sample_r, input sample_valid, output sample_ready);
endinterface

// File: rtl/pdm_mic_rx.sv
// PDM microphone front end: mic clock generation, L/R sampling, boxcar decimation
// and a one-entry PCM output buffer with sticky overrun.
module pdm_mic_rx #(
    parameter int DIV_STD   = 12,
    parameter int DIV_ULTRA = 6,
    parameter int DECIM     = 64,
    parameter int OUT_W     = 16,
    parameter int STEREO    = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             mode_ultra,
    input  logic             pdm_data,
    output logic             mic_clk,
    pdm_mic_rx_if.master     pcm,
    output logic             overrun,
    input  logic             clr_overrun
);
    localparam int DMAX   = (DIV_STD > DIV_ULTRA) ? DIV_STD : DIV_ULTRA;
    localparam int HC_W   = $clog2(DMAX + 1);
    localparam int PC_W   = $clog2(DECIM);
    localparam int ONES_W = $clog2(DECIM + 1);

    logic [HC_W-1:0]   hc;
    logic [HC_W-1:0]   hc_last;
    logic              mode_q;
    logic              mode_eff;
    logic              started;
    logic [PC_W-1:0]   pc;
    logic [ONES_W-1:0] ones_l;
    logic [ONES_W-1:0] ones_r;
    logic [ONES_W-1:0] ones_r_fin;
    logic              terminal;
    logic              fall_t;
    logic              rise_t;
    logic              block_end;
    logic [OUT_W-1:0]  res_l;
    logic [OUT_W-1:0]  res_r;
    logic              load_pend;
    logic [OUT_W-1:0]  pend_l;
    logic [OUT_W-1:0]  pend_r;
    logic [OUT_W-1:0]  buf_l;
    logic [OUT_W-1:0]  buf_r;
    logic              valid_q;

    // Before the first clock after reset the latch has not captured mode_ultra yet.
    always_comb begin
        mode_eff   = started ? mode_q : mode_ultra;
        hc_last    = mode_eff ? HC_W'(DIV_ULTRA - 1) : HC_W'(DIV_STD - 1);
        terminal   = enable && (hc == hc_last);
        fall_t     = terminal && mic_clk;
        rise_t     = terminal && !mic_clk;
        block_end  = rise_t && (pc == PC_W'(DECIM - 1));
        ones_r_fin = ones_r + ONES_W'(pdm_data && (STEREO != 0));
        res_l      = (OUT_W'(ones_l) << 1) - OUT_W'(DECIM);
        res_r      = '0;
        if (STEREO != 0) begin
            res_r = (OUT_W'(ones_r_fin) << 1) - OUT_W'(DECIM);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hc      <= '0;
            mic_clk <= 1'b1;
            mode_q  <= 1'b0;
            started <= 1'b0;
        end else begin
            started <= 1'b1;
            if (!started || !enable || terminal) begin
                mode_q <= mode_ultra;
            end
            if (!enable) begin
                hc      <= '0;
                mic_clk <= 1'b1;
            end else if (terminal) begin
                hc      <= '0;
                mic_clk <= ~mic_clk;
            end else begin
                hc <= hc + 1'b1;
            end
        end
    end

    // The final right sample of a block is folded in via ones_r_fin, so nothing is lost at the boundary.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc        <= '0;
            ones_l    <= '0;
            ones_r    <= '0;
            load_pend <= 1'b0;
            pend_l    <= '0;
            pend_r    <= '0;
        end else begin
            load_pend <= block_end;
            if (block_end) begin
                pend_l <= res_l;
                pend_r <= res_r;
            end
            if (!enable) begin
                pc     <= '0;
                ones_l <= '0;
                ones_r <= '0;
            end else if (rise_t) begin
                if (block_end) begin
                    pc     <= '0;
                    ones_l <= '0;
                    ones_r <= '0;
                end else begin
                    pc     <= pc + 1'b1;
                    ones_r <= ones_r_fin;
                end
            end else if (fall_t && pdm_data) begin
                ones_l <= ones_l + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_l   <= '0;
            buf_r   <= '0;
            valid_q <= 1'b0;
            overrun <= 1'b0;
        end else begin
            if (load_pend) begin
                buf_l   <= pend_l;
                buf_r   <= pend_r;
                valid_q <= 1'b1;
            end else if (valid_q && pcm.sample_ready) begin
                valid_q <= 1'b0;
            end
            if (load_pend && valid_q && !pcm.sample_ready) begin
                overrun <= 1'b1;
            end else if (clr_overrun) begin
                overrun <= 1'b0;
            end
        end
    end

    assign pcm.sample_l     = buf_l;
    assign pcm.sample_r     = buf_r;
    assign pcm.sample_valid = valid_q;
endmodule

// File: tb/tb_pdm_mic_rx.sv
// Directed bench for pdm_mic_rx: default build (clock/decimation), a small
// DECIM=4 build (backpressure/abort) and a mono build.
module tb_pdm_mic_rx;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic en_a, mode_a, pdm_a, mclk_a, ovr_a, clr_a, pat_a;
    logic lbit = 1'b0;
    pdm_mic_rx_if #(.OUT_W(16)) a_if();
    pdm_mic_rx u_a (
        .clk(clk), .rst_n(rst_n), .enable(en_a), .mode_ultra(mode_a), .pdm_data(pdm_a),
        .mic_clk(mclk_a), .pcm(a_if.master), .overrun(ovr_a), .clr_overrun(clr_a)
    );
    always_comb pdm_a = mclk_a & (pat_a ? lbit : 1'b1);
    always @(negedge mclk_a) lbit <= ~lbit;

    logic en_b, mode_b, pdm_b, mclk_b, ovr_b, clr_b;
    pdm_mic_rx_if #(.OUT_W(16)) b_if();
    pdm_mic_rx #(.DIV_STD(2), .DIV_ULTRA(1), .DECIM(4), .OUT_W(16), .STEREO(1)) u_b (
        .clk(clk), .rst_n(rst_n), .enable(en_b), .mode_ultra(mode_b), .pdm_data(pdm_b),
        .mic_clk(mclk_b), .pcm(b_if.master), .overrun(ovr_b), .clr_overrun(clr_b)
    );

    logic en_c, mode_c, pdm_c, mclk_c, ovr_c, clr_c;
    pdm_mic_rx_if #(.OUT_W(16)) c_if();
    pdm_mic_rx #(.DIV_STD(2), .DIV_ULTRA(1), .DECIM(4), .OUT_W(16), .STEREO(0)) u_c (
        .clk(clk), .rst_n(rst_n), .enable(en_c), .mode_ultra(mode_c), .pdm_data(pdm_c),
        .mic_clk(mclk_c), .pcm(c_if.master), .overrun(ovr_c), .clr_overrun(clr_c)
    );

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Cycles until mic_clk_a next toggles; optionally switches mode_a after sw_at cycles.
    task automatic meas_a(input int sw_at, input logic sw_val, output int n);
        logic m;
        m = mclk_a;
        n = 0;
        while (n < 100) begin
            tick();
            n++;
            if (mclk_a != m) break;
            if (n == sw_at) mode_a = sw_val;
        end
    endtask

    task automatic wait_valid_a(input string tag, output int lat);
        int n;
        int rise_n;
        logic pm;
        n = 0;
        rise_n = -1000;
        pm = mclk_a;
        while (!a_if.sample_valid && n < 4000) begin
            tick();
            n++;
            if (mclk_a && !pm) rise_n = n;
            pm = mclk_a;
        end
        lat = n - rise_n;
        chk(tag, a_if.sample_valid, 1);
    endtask

    task automatic wait_valid_b(input string tag);
        int n;
        n = 0;
        while (!b_if.sample_valid && n < 200) begin
            tick();
            n++;
        end
        chk(tag, b_if.sample_valid, 1);
    endtask

    task automatic wait_valid_c(input string tag);
        int n;
        n = 0;
        while (!c_if.sample_valid && n < 200) begin
            tick();
            n++;
        end
        chk(tag, c_if.sample_valid, 1);
    endtask

    initial begin
        int n;
        int lat;
        rst_n = 1'b0;
        en_a = 1'b1; mode_a = 1'b0; clr_a = 1'b0; pat_a = 1'b0; a_if.sample_ready = 1'b0;
        en_b = 1'b0; mode_b = 1'b0; clr_b = 1'b0; pdm_b = 1'b0; b_if.sample_ready = 1'b0;
        en_c = 1'b0; mode_c = 1'b0; clr_c = 1'b0; pdm_c = 1'b1; c_if.sample_ready = 1'b1;
        repeat (3) tick();
        chk("rst_mic_clk", mclk_a, 1);
        chk("rst_valid", a_if.sample_valid, 0);
        chk("rst_l", int'($signed(a_if.sample_l)), 0);
        chk("rst_r", int'($signed(a_if.sample_r)), 0);
        chk("rst_overrun", ovr_a, 0);

        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        while (mclk_a && n < 100) begin
            tick();
            n++;
        end
        chk("first_fall", n, 12);

        meas_a(0, 1'b0, n);  chk("half_std", n, 12);
        meas_a(8, 1'b1, n);  chk("half_switch", n, 12);
        meas_a(0, 1'b1, n);  chk("half_ultra1", n, 6);
        meas_a(0, 1'b1, n);  chk("half_ultra2", n, 6);
        meas_a(1, 1'b0, n);  chk("half_back_cur", n, 6);
        meas_a(0, 1'b0, n);  chk("half_back_std", n, 12);

        wait_valid_a("a_valid1", lat);
        chk("a_latency", lat, 1);
        chk("a_l_full", int'($signed(a_if.sample_l)), 64);
        chk("a_r_zero", int'($signed(a_if.sample_r)), -64);
        a_if.sample_ready = 1'b1;
        tick();
        chk("a_hs_clear", a_if.sample_valid, 0);
        pat_a = 1'b1;
        wait_valid_a("a_valid2", lat);
        chk("a_l_alt", int'($signed(a_if.sample_l)), 0);
        chk("a_r_alt", int'($signed(a_if.sample_r)), -64);

        // Small build: backpressure, overrun, set-wins, load with handshake.
        en_b = 1'b1; pdm_b = 1'b1;
        wait_valid_b("b_valid1");
        chk("b_l1", int'($signed(b_if.sample_l)), 4);
        chk("b_r1", int'($signed(b_if.sample_r)), 4);
        chk("b_ovr0", ovr_b, 0);
        pdm_b = 1'b0;
        n = 0;
        while (b_if.sample_l == 16'd4 && n < 100) begin tick(); n++; end
        chk("b_l2_held", int'($signed(b_if.sample_l)), -4);
        chk("b_r2_held", int'($signed(b_if.sample_r)), -4);
        chk("b_valid2", b_if.sample_valid, 1);
        chk("b_ovr_set", ovr_b, 1);
        pdm_b = 1'b1;
        clr_b = 1'b1;
        tick();
        clr_b = 1'b0;
        chk("b_ovr_clr", ovr_b, 0);
        clr_b = 1'b1;
        n = 0;
        while (b_if.sample_l == 16'hFFFC && n < 100) begin tick(); n++; end
        chk("b_l3", int'($signed(b_if.sample_l)), 4);
        chk("b_set_wins", ovr_b, 1);
        pdm_b = 1'b0;
        tick();
        clr_b = 1'b0;
        chk("b_ovr_clr2", ovr_b, 0);
        repeat (14) tick();
        b_if.sample_ready = 1'b1;
        tick();
        chk("b_load_hs_valid", b_if.sample_valid, 1);
        chk("b_load_hs_l", int'($signed(b_if.sample_l)), -4);
        chk("b_load_hs_ovr", ovr_b, 0);
        tick();
        chk("b_hs_only", b_if.sample_valid, 0);
        b_if.sample_ready = 1'b0;

        // Abort mid-block with ones, restart with zeros.
        pdm_b = 1'b1;
        wait_valid_b("b_valid5");
        repeat (7) tick();
        en_b = 1'b0;
        repeat (10) tick();
        chk("b_idle_valid", b_if.sample_valid, 1);
        chk("b_idle_mclk", mclk_b, 1);
        b_if.sample_ready = 1'b1;
        tick();
        b_if.sample_ready = 1'b0;
        chk("b_idle_consume", b_if.sample_valid, 0);
        pdm_b = 1'b0;
        en_b = 1'b1;
        n = 0;
        while (mclk_b && n < 100) begin tick(); n++; end
        chk("b_restart_fall", n, 2);
        wait_valid_b("b_valid_restart");
        chk("b_restart_l", int'($signed(b_if.sample_l)), -4);
        chk("b_restart_r", int'($signed(b_if.sample_r)), -4);

        // Mono build.
        en_c = 1'b1;
        for (int k = 0; k < 2; k++) begin
            wait_valid_c("c_valid");
            chk("c_l", int'($signed(c_if.sample_l)), 4);
            chk("c_r", int'($signed(c_if.sample_r)), 0);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
